diff_msb_scanner: RTL and testbench

//  Multi-cycle front end for the RISC difference decoder. Accepts two operands, XORs them and scans

---
 rtl/diff_msb_scanner_pkg.sv | 18 +
 rtl/diff_msb_scanner_chunk_detect.sv | 29 ++
 rtl/diff_msb_scanner.sv | 127 ++++++++++++
 tb/tb_diff_msb_scanner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_msb_scanner_pkg.sv
// Package: diff_msb_scanner_pkg
// Shared constants and the scanner FSM state type for the difference
// scanner and the downstream one-hot-to-count decoder.
//   DEF_WIDTH      default operand / one-hot width
//   DEF_SCAN_BITS  default number of bits examined per scan cycle
//   scan_state_t   SCAN_IDLE=0, SCAN_RUN=1, SCAN_DONE=2
package diff_msb_scanner_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_SCAN_BITS = 4;

    typedef enum logic [1:0] {
        SCAN_IDLE = 2'd0,
        SCAN_RUN  = 2'd1,
        SCAN_DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/diff_msb_scanner_chunk_detect.sv
// Module: msb_chunk_detect
// Combinational highest-set-bit detector for one scan chunk.
// Ports:
//   bits    in   N  chunk to examine
//   onehot  out  N  one-hot of the highest set bit of bits (zero if none)
//   hit     out  1  bits is non-zero
module msb_chunk_detect #(
    parameter int N = 4
) (
    input  logic [N-1:0] bits,
    output logic [N-1:0] onehot,
    output logic         hit
);

    // Ascending scan: each set bit overwrites the previous result, so the
    // highest set bit is the one left standing.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (bits[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign hit = |bits;

endmodule

// File: rtl/diff_msb_scanner.sv
// Module: diff_msb_scanner
// Multi-cycle front end for the difference decoder. Latches op_a^op_b,
// scans it from the MSB in SCAN_BITS-wide chunks and produces a one-hot
// vector of the highest differing bit (all-zero for equal operands),
// presented under a valid/ready handshake.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid may not depend on ready. in_ready is high only in IDLE,
// out_valid only in DONE, and diff is stable for the whole DONE period.
//
// Configuration macro: DIFF_SCAN_EARLY_EXIT_EN
//   defined   - leave SCAN in the cycle the first non-zero chunk is found
//   undefined - always scan every chunk (constant latency)
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      idle, can accept a pair
//   op_a       in   WIDTH  first operand
//   op_b       in   WIDTH  second operand
//   out_valid  out  1      diff valid, held until out_ready
//   out_ready  in   1      consumer accepts diff
//   diff       out  WIDTH  one-hot of highest differing bit, or zero
//   busy       out  1      FSM not in IDLE
module diff_msb_scanner
    import diff_msb_scanner_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SCAN_BITS = DEF_SCAN_BITS   // must divide WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / SCAN_BITS;
    localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SH_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    scan_state_t          state;
    scan_state_t          state_next;
    logic [WIDTH-1:0]     x;
    logic [PTR_W-1:0]     ptr;
    logic                 found;

    logic [SH_W-1:0]      base;
    logic [SCAN_BITS-1:0] chunk;
    logic [SCAN_BITS-1:0] chunk_oh;
    logic                 chunk_hit;
    logic [WIDTH-1:0]     placed;

    // Bit offset of the chunk under the pointer.
    assign base  = SH_W'(ptr) * SH_W'(SCAN_BITS);
    assign chunk = x[base +: SCAN_BITS];

    msb_chunk_detect #(.N(SCAN_BITS)) u_detect (
        .bits   (chunk),
        .onehot (chunk_oh),
        .hit    (chunk_hit)
    );

    // Move the chunk-local one-hot to its absolute bit position.
    assign placed = WIDTH'(chunk_oh) << base;

    assign in_ready  = (state == SCAN_IDLE);
    assign out_valid = (state == SCAN_DONE);
    assign busy      = (state != SCAN_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= SCAN_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SCAN_IDLE: if (in_valid) state_next = SCAN_RUN;
            SCAN_RUN: begin
                if (ptr == '0) state_next = SCAN_DONE;
`ifdef DIFF_SCAN_EARLY_EXIT_EN
                if (!found && chunk_hit) state_next = SCAN_DONE;
`endif
            end
            SCAN_DONE: if (out_ready) state_next = SCAN_IDLE;
            default:   state_next = SCAN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x     <= '0;
            ptr   <= '0;
            found <= 1'b0;
            diff  <= '0;
        end else begin
            case (state)
                SCAN_IDLE: begin
                    if (in_valid) begin
                        x     <= op_a ^ op_b;
                        ptr   <= PTR_W'(NCHUNK - 1);
                        found <= 1'b0;
                        diff  <= '0;
                    end
                end
                SCAN_RUN: begin
                    // First non-zero chunk from the top wins; later (lower)
                    // chunks are ignored once found is set.
                    if (!found && chunk_hit) begin
                        diff  <= placed;
                        found <= 1'b1;
                    end
                    if (ptr != '0) ptr <= ptr - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_diff_msb_scanner.sv
module tb_diff_msb_scanner;

    localparam int W      = 32;
    localparam int SB     = 4;
    localparam int NCHUNK = W / SB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         busy;

    diff_msb_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int           lat_q[$];   // expected posedges from accept to DONE entry
    int           acc_q[$];   // cycle count just after the accept edge
    int           ready_pct = 100;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int msb_index(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        int m;
        x = a ^ b;
        m = -1;
        for (int i = 0; i < W; i++) if (x[i]) m = i;
        return m;
    endfunction

    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        int m;
        r = '0;
        m = msb_index(a, b);
        if (m >= 0) r[m] = 1'b1;
        return r;
    endfunction

    // Spec latency N+k counts cycles; k-1 posedges elapse from accept to
    // the edge that enters DONE.
    function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        int m;
        m = msb_index(a, b);
`ifdef DIFF_SCAN_EARLY_EXIT_EN
        if (m >= 0) return NCHUNK - m / SB;
`endif
        if (m < -1) return 0;
        return NCHUNK;
    endfunction

    // ---------------- drivers ----------------
    always @(posedge clk) begin
        #1;
        out_ready = ($urandom_range(99, 0) < ready_pct);
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 1'b0, 1'b1);
            return;
        end
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        exp_q.push_back(ref_diff(a, b));
        lat_q.push_back(ref_lat(a, b));
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", W'(exp_q.size()), '0);
    endtask

    // ---------------- monitor ----------------
    logic         prev_ov = 1'b0;
    logic         prev_hs = 1'b0;
    logic [W-1:0] held_diff = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_ov && !prev_hs) begin
                check("hold_valid", W'(out_valid), W'(1));
                check("hold_diff", diff, held_diff);
            end
            if (out_valid && !prev_ov) begin
                if (lat_q.size() == 0 || acc_q.size() == 0)
                    check("spurious_valid", W'(1), W'(0));
                else
                    check("latency", W'(cyc - acc_q[0]), W'(lat_q[0]));
            end
            prev_hs = 1'b0;
            if (out_valid && out_ready) begin
                prev_hs = 1'b1;
                if (exp_q.size() == 0) begin
                    check("spurious_output", W'(1), W'(0));
                end else begin
                    check("diff", diff, exp_q.pop_front());
                    void'(lat_q.pop_front());
                    if (acc_q.size() != 0) void'(acc_q.pop_front());
                end
            end
            if (out_valid) check("onehot", W'($countones(diff) <= 1), W'(1));
            held_diff = diff;
            prev_ov   = out_valid;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", W'(in_ready), W'(1));
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_diff", diff, '0);
        check("reset_busy", W'(busy), W'(0));

        // Directed vectors.
        ready_pct = 100;
        send(32'hFFFF0000, 32'hFFFF0001);
        send(32'h80000000, 32'h00000000);
        send(32'h12345678, 32'h12345678);
        send(32'h0F0F0000, 32'h0A0F0000);
        drain();

        // Output held with out_ready low; in_valid pulses while busy ignored.
        ready_pct = 0;
        send(32'h00F00000, 32'h00100000);
        for (int i = 0; i < NCHUNK + 6; i++) begin
            @(negedge clk);
            check("busy_in_ready", W'(in_ready), W'(0));
            check("busy_flag", W'(busy), W'(1));
            op_a     = $urandom;
            op_b     = $urandom;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        ready_pct = 100;
        drain();

        // Reset in the third SCAN cycle abandons the pair.
        send(32'hDEADBEEF, 32'h00000000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_diff", diff, '0);
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_busy", W'(busy), W'(0));
        send(32'h00000300, 32'h00000100);
        drain();

        // Randomized pairs with random consumer back-pressure.
        for (int n = 0; n < 60; n++) begin
            ready_pct = $urandom_range(100, 25);
            a = $urandom;
            case ($urandom_range(3, 0))
                0:       b = a;
                1:       b = a ^ (W'(1) << $urandom_range(W - 1, 0));
                2:       b = a ^ (W'($urandom) >> $urandom_range(W - 1, 0));
                default: b = $urandom;
            endcase
            send(a, b);
        end
        ready_pct = 100;
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
